bram_fifo: RTL and testbench

- Parametrised synchronous FIFO for iCE40 block RAM.
- Single clock domain, one write port and one read port, with a first-word-fall-through valid/ready read interface.
- Buffers pulse/sensor data words between the front-end decoders and the downstream consumer (SPI/UART packetiser).
- Depth and width are generic. The storage array must infer SB_RAM40_4K primitives with a registered read (1-cycle RAM read latency).

---
 rtl/bram_fifo.sv | 123 ++++++++++++
 tb/tb_bram_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo.sv
// Single-clock FIFO on inferred iCE40 block RAM with a first-word-fall-through
// valid/ready read side built from the RAM output register plus one output register.
module bram_fifo #(
    parameter int WIDTH             = 16,
    parameter int DEPTH_LOG2        = 8,
    parameter int ALMOST_FULL_LEVEL = (2 ** DEPTH_LOG2) - 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                wr_en,
    output logic                full,
    output logic                almost_full,
    output logic                overflow,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_C     = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [WIDTH-1:0]      ram_q_r;
    logic                  ram_vld_r;
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic [DEPTH_LOG2-1:0] rptr_r;
    logic [CW-1:0]         count_r;
    logic [WIDTH-1:0]      rd_data_r;
    logic                  rd_valid_r;
    logic                  overflow_r;

    logic                  flush_s;
    logic                  full_s;
    logic                  almost_full_s;
    logic                  push_s;
    logic                  pop_s;
    logic [CW-1:0]         unread_s;
    logic                  out_load_s;
    logic                  ram_rd_s;
    logic                  ram_wr_s;

    // Handshake decode and prefetch scheduling from registered state.
    always_comb begin
        flush_s       = reset | clear;
        full_s        = (count_r == DEPTH_C);
        almost_full_s = (count_r >= AF_C);
        push_s        = wr_en & ~full_s;
        pop_s         = rd_valid_r & rd_ready;
        // Words sitting in the array that have not been read out yet; all were
        // written at an earlier edge, so reading rptr never collides with a write.
        unread_s      = count_r - {{(CW-1){1'b0}}, rd_valid_r} - {{(CW-1){1'b0}}, ram_vld_r};
        out_load_s    = ram_vld_r & (~rd_valid_r | pop_s);
        ram_rd_s      = ~flush_s & (unread_s != CNT_ZERO) & (~ram_vld_r | out_load_s);
        ram_wr_s      = ~flush_s & push_s;
    end

    // Block RAM: write port plus registered read that holds when not enabled.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            mem_r[wptr_r] <= wr_data;
        end
        if (ram_rd_s) begin
            ram_q_r <= mem_r[rptr_r];
        end
    end

    // Pointers, occupancy, output stage and sticky overflow.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            wptr_r     <= PTR_ZERO;
            rptr_r     <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            ram_vld_r  <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (ram_rd_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (ram_rd_s) begin
                ram_vld_r <= 1'b1;
            end else if (out_load_s) begin
                ram_vld_r <= 1'b0;
            end
            if (out_load_s) begin
                rd_valid_r <= 1'b1;
                rd_data_r  <= ram_q_r;
            end else if (pop_s) begin
                rd_valid_r <= 1'b0;
            end
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign full        = full_s;
    assign almost_full = almost_full_s;
    assign overflow    = overflow_r;
    assign rd_data     = rd_data_r;
    assign rd_valid    = rd_valid_r;
    assign count       = count_r;

endmodule

// File: tb/tb_bram_fifo.sv
// Self-checking bench for bram_fifo: directed vector table, hand sequences and a
// randomized run, all compared against a queue-plus-timestamp reference model.
module tb_bram_fifo;

    localparam int W     = 16;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic          clk = 1'b0;
    logic          reset, clear, wr_en, rd_ready;
    logic [W-1:0]  wr_data;
    logic          full, almost_full, overflow, rd_valid;
    logic [W-1:0]  rd_data;
    logic [DL:0]   count;

    always #5 clk = ~clk;

    bram_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .ALMOST_FULL_LEVEL(AFL)) dut (
        .clk(clk), .reset(reset), .clear(clear), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .almost_full(almost_full), .overflow(overflow),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: stored words with the edge they were pushed at. A word is
    // readable once it has been prefetched (one edge after its push, and not
    // before its predecessor left the prefetch slot) and the output slot is free.
    logic [W-1:0] mq_data[$];
    int           mq_p[$];
    int           prev_a = -100;
    int           prev_d = -100;
    bit           m_ovf  = 1'b0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int head_appear();
        int r;
        r = imax(mq_p[0] + 1, prev_a);
        return imax(r + 1, prev_d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_update();
        bit fullm, vis, pop, push;
        if (reset || clear) begin
            mq_data.delete();
            mq_p.delete();
            m_ovf  = 1'b0;
            prev_a = -100;
            prev_d = -100;
        end else begin
            fullm = (mq_data.size() == DEPTH);
            vis   = (mq_data.size() > 0) && (head_appear() <= edge_n - 1);
            pop   = vis && rd_ready;
            push  = wr_en && !fullm;
            if (wr_en && fullm) m_ovf = 1'b1;
            if (pop) begin
                prev_a = head_appear();
                prev_d = edge_n;
                void'(mq_data.pop_front());
                void'(mq_p.pop_front());
            end
            if (push) begin
                mq_data.push_back(wr_data);
                mq_p.push_back(edge_n);
            end
        end
    endtask

    task automatic compare_model();
        bit exp_v;
        exp_v = (mq_data.size() > 0) && (head_appear() <= edge_n);
        check("m_rd_valid", rd_valid, exp_v);
        if (exp_v) check("m_rd_data", rd_data, mq_data[0]);
        check("m_count", count, mq_data.size());
        check("m_full", full, mq_data.size() == DEPTH);
        check("m_almost_full", almost_full, mq_data.size() >= AFL);
        check("m_overflow", overflow, m_ovf);
    endtask

    task automatic step(input bit rst, input bit clr, input bit we, input logic [W-1:0] wd, input bit rr);
        reset    = rst;
        clear    = clr;
        wr_en    = we;
        wr_data  = wd;
        rd_ready = rr;
        @(posedge clk);
        edge_n++;
        model_update();
        #1;
        compare_model();
    endtask

    typedef struct {
        bit           rst, clr, we, rr;
        logic [W-1:0] wd;
        bit           e_valid, e_chkdata;
        logic [W-1:0] e_data;
        int           e_count;
        bit           e_full, e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rst, input bit we, input logic [W-1:0] wd, input bit rr,
                                input bit ev, input bit ecd, input logic [W-1:0] ed, input int ec);
        vec_t v;
        v.rst = rst; v.clr = 1'b0; v.we = we; v.wd = wd; v.rr = rr;
        v.e_valid = ev; v.e_chkdata = ecd; v.e_data = ed; v.e_count = ec;
        v.e_full = 1'b0; v.e_ovf = 1'b0;
        return v;
    endfunction

    initial begin
        int n, pops;
        logic [W-1:0] seq;

        // Directed table: single word fall-through, hold while stalled, pop.
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 0));
        vecs.push_back(mk(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1));
        for (int i = 0; i < 11; i++)
            vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].we, vecs[i].wd, vecs[i].rr);
            check("t_rd_valid", rd_valid, vecs[i].e_valid);
            if (vecs[i].e_chkdata) check("t_rd_data", rd_data, vecs[i].e_data);
            check("t_count", count, vecs[i].e_count);
            check("t_full", full, vecs[i].e_full);
            check("t_overflow", overflow, vecs[i].e_ovf);
        end

        // Fill to full, overflow on the 17th push, drain in order.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, W'(i), 1'b0);
            check("fill_almost_full", almost_full, (i + 1) >= AFL);
            check("fill_full", full, (i + 1) == DEPTH);
        end
        step(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_count", count, 16);
        n = 0;
        for (int c = 0; c < 40 && n < DEPTH; c++) begin
            if (rd_valid) begin
                check("drain_data", rd_data, W'(n));
                n++;
            end
            step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        end
        check("drain_words", n, DEPTH);
        check("drain_count", count, 0);
        check("ovf_sticky", overflow, 1'b1);

        // Five words held, then clear together with push and pop.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, W'(16'h0100 + i), 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("pre_clear_valid", rd_valid, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1);
        check("clr_count", count, 0);
        check("clr_valid", rd_valid, 1'b0);
        check("clr_full", full, 1'b0);
        check("clr_ovf", overflow, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h5A5A, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("clr_lat1_valid", rd_valid, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("clr_lat2_valid", rd_valid, 1'b1);
        check("clr_lat2_data", rd_data, 16'h5A5A);

        // Streaming push with the consumer always ready.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        pops = 0;
        seq  = 16'h0000;
        for (int i = 0; i < 1000; i++) begin
            if (rd_valid) begin
                check("stream_data", rd_data, W'(pops));
                pops++;
            end else if (i >= 3) begin
                check("stream_gap", rd_valid, 1'b1);
            end
            step(1'b0, 1'b0, 1'b1, seq, 1'b1);
            seq = seq + 16'h0001;
        end
        check("stream_pops", pops, 997);
        check("stream_count", count, 3);

        // Randomized traffic in two mixes.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 20000; i++) begin
            bit we, rr;
            if (i < 10000) begin
                we = ($urandom_range(99) < 50);
                rr = ($urandom_range(99) < 30);
            end else begin
                we = ($urandom_range(99) < 30);
                rr = ($urandom_range(99) < 70);
            end
            step(1'b0, 1'b0, we, W'($urandom), rr);
        end

        // Reset while full with a word presented.
        for (int i = 0; i < DEPTH + 3; i++) step(1'b0, 1'b0, i < DEPTH, W'(16'h0F00 + i), 1'b0);
        check("pre_rst_full", full, 1'b1);
        check("pre_rst_valid", rd_valid, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 16'h0000);
        check("rst_count", count, 0);
        check("rst_full", full, 1'b0);
        check("rst_almost_full", almost_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
